// File: rtl/lsu_pkg.sv
// Shared types and encodings for the load/store bus bridge.
package lsu_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_REQ    = 3'd1,
    S_WAIT_R = 3'd2,
    S_DONE   = 3'd3,
    S_ERR    = 3'd4
  } state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_MISAL   = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

endpackage

// File: rtl/lsu_lane_fmt.sv
// Byte-lane formatting: byte enables, store replication, load extraction and
// extension, and the alignment/legal-funct3 check.
module lsu_lane_fmt
  import lsu_pkg::*;
(
  input  logic        we,
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep,
  output logic [31:0] rdata_ext,
  output logic        misal
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  assign byte_lane = rdata[{addr_lo, 3'b000} +: 8];
  assign half_lane = addr_lo[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    be        = '0;
    wdata_rep = wdata;
    rdata_ext = rdata;
    misal     = 1'b0;
    case (funct3)
      F3_B: begin
        be        = 4'b0001 << addr_lo;
        wdata_rep = {4{wdata[7:0]}};
        rdata_ext = {{24{byte_lane[7]}}, byte_lane};
      end
      F3_BU: begin
        be        = 4'b0001 << addr_lo;
        wdata_rep = {4{wdata[7:0]}};
        rdata_ext = {24'h0, byte_lane};
      end
      F3_H: begin
        be        = 4'b0011 << {addr_lo[1], 1'b0};
        wdata_rep = {2{wdata[15:0]}};
        rdata_ext = {{16{half_lane[15]}}, half_lane};
        misal     = addr_lo[0];
      end
      F3_HU: begin
        be        = 4'b0011 << {addr_lo[1], 1'b0};
        wdata_rep = {2{wdata[15:0]}};
        rdata_ext = {16'h0, half_lane};
        misal     = addr_lo[0];
      end
      F3_W: begin
        be    = 4'b1111;
        misal = |addr_lo;
      end
      default: misal = 1'b1;
    endcase
    // Unsigned variants exist only for loads.
    if (we && funct3[2]) misal = 1'b1;
  end

endmodule

// File: rtl/lsu_bus_bridge.sv
// Load/store bridge from the single-cycle core data port to a valid/ready
// request, rvalid response memory bus, with stall, error and timeout handling.
module lsu_bus_bridge
  import lsu_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [2:0]        core_funct3,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [31:0]       core_wdata,
  output logic              core_stall,
  output logic              core_done,
  output logic [31:0]       core_rdata,
  output logic [1:0]        core_err,
  output logic              bus_valid,
  input  logic              bus_ready,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [3:0]        bus_be,
  output logic [31:0]       bus_wdata,
  input  logic              bus_rvalid,
  input  logic [31:0]       bus_rdata
);

  localparam logic [TO_W-1:0] TO_LAST = TO_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  state_e            state;
  logic              we_q;
  logic [2:0]        f3_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       rdata_q;
  logic [1:0]        err_q;
  logic [TO_W-1:0]   to_cnt;

  logic              in_idle, in_req, in_wait, timed_out;
  logic              fmt_we, fmt_misal;
  logic [2:0]        fmt_f3;
  logic [1:0]        fmt_lo;
  logic [3:0]        fmt_be;
  logic [31:0]       fmt_wdata, fmt_rdata;

  assign in_idle = (state == S_IDLE);
  assign in_req  = (state == S_REQ);
  assign in_wait = (state == S_WAIT_R);

  // One formatter serves both the IDLE alignment check (live core inputs)
  // and the REQ/WAIT_R payload and load path (latched access).
  assign fmt_we = in_idle ? core_we          : we_q;
  assign fmt_f3 = in_idle ? core_funct3      : f3_q;
  assign fmt_lo = in_idle ? core_addr[1:0]   : addr_q[1:0];

  lsu_lane_fmt u_fmt (
    .we        (fmt_we),
    .funct3    (fmt_f3),
    .addr_lo   (fmt_lo),
    .wdata     (wdata_q),
    .rdata     (bus_rdata),
    .be        (fmt_be),
    .wdata_rep (fmt_wdata),
    .rdata_ext (fmt_rdata),
    .misal     (fmt_misal)
  );

  assign timed_out = (TIMEOUT != 0) && (in_req || in_wait) && (to_cnt == TO_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      we_q    <= 1'b0;
      f3_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= ERR_NONE;
      to_cnt  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (core_req) begin
            we_q    <= core_we;
            f3_q    <= core_funct3;
            addr_q  <= core_addr;
            wdata_q <= core_wdata;
            to_cnt  <= '0;
            if (fmt_misal) begin
              err_q <= ERR_MISAL;
              state <= S_ERR;
            end else begin
              state <= S_REQ;
            end
          end
        end
        S_REQ: begin
          to_cnt <= to_cnt + TO_W'(1);
          if (timed_out) begin
            err_q <= ERR_TIMEOUT;
            state <= S_ERR;
          end else if (bus_ready) begin
            state <= we_q ? S_DONE : S_WAIT_R;
          end
        end
        S_WAIT_R: begin
          to_cnt <= to_cnt + TO_W'(1);
          if (timed_out) begin
            err_q <= ERR_TIMEOUT;
            state <= S_ERR;
          end else if (bus_rvalid) begin
            rdata_q <= fmt_rdata;
            state   <= S_DONE;
          end
        end
        S_DONE:  state <= S_IDLE;
        S_ERR:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign core_stall = core_req && (in_idle || in_req || in_wait);
  assign core_done  = (state == S_DONE) || (state == S_ERR);
  assign core_err   = (state == S_ERR) ? err_q : ERR_NONE;
  assign core_rdata = rdata_q;

  assign bus_valid = in_req;
  assign bus_we    = in_req && we_q;
  assign bus_addr  = in_req ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
  assign bus_be    = in_req ? fmt_be    : '0;
  assign bus_wdata = in_req ? fmt_wdata : '0;

endmodule

// File: tb/tb_lsu_bus_bridge.sv
// Directed bench for lsu_bus_bridge; inputs driven and outputs sampled away
// from the rising edge.
module tb_lsu_bus_bridge;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        core_req = 1'b0, core_we = 1'b0;
  logic [2:0]  core_funct3 = '0;
  logic [31:0] core_addr = '0, core_wdata = '0;
  logic        core_stall, core_done;
  logic [31:0] core_rdata;
  logic [1:0]  core_err;
  logic        bus_valid, bus_we;
  logic        bus_ready = 1'b0, bus_rvalid = 1'b0;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_be;
  logic [31:0] bus_rdata = '0;

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  lsu_bus_bridge #(.ADDR_W(32), .TIMEOUT(4), .TO_W(8)) dut (
    .clk(clk), .rst(rst),
    .core_req(core_req), .core_we(core_we), .core_funct3(core_funct3),
    .core_addr(core_addr), .core_wdata(core_wdata),
    .core_stall(core_stall), .core_done(core_done),
    .core_rdata(core_rdata), .core_err(core_err),
    .bus_valid(bus_valid), .bus_ready(bus_ready), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_be(bus_be), .bus_wdata(bus_wdata),
    .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
  );

  task automatic drive_req(input logic we, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] wd);
    core_req = 1'b1; core_we = we; core_funct3 = f3;
    core_addr = addr; core_wdata = wd;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    @(negedge clk); #1;
    vecs++;
    if ({core_stall, core_done, core_err, bus_valid, bus_we, bus_be} !== 10'h0) begin
      errs++; $display("FAIL reset_ctrl got %b want 0", {core_stall, core_done, core_err, bus_valid, bus_we, bus_be});
    end
    vecs++;
    if (core_rdata !== 32'h0) begin errs++; $display("FAIL reset_rdata got %h want 0", core_rdata); end
    vecs++;
    if ({bus_addr, bus_wdata} !== 64'h0) begin errs++; $display("FAIL reset_bus got %h want 0", {bus_addr, bus_wdata}); end
    @(negedge clk); rst = 1'b1;
  endtask

  task automatic test_store_word();
    int stalls, hs, done_at;
    stalls = 0; hs = 0; done_at = -1;
    @(negedge clk); drive_req(1'b1, F3_W, 32'h100, 32'hDEADBEEF); bus_ready = 1'b1;
    for (int i = 0; i < 20 && done_at < 0; i++) begin
      #1;
      if (core_stall) stalls++;
      if (bus_valid && bus_ready) begin
        hs++; vecs++;
        if ({bus_we, bus_be, bus_addr, bus_wdata} !== {1'b1, 4'b1111, 32'h100, 32'hDEADBEEF}) begin
          errs++; $display("FAIL sw_payload got %h want %h", {bus_we, bus_be, bus_addr, bus_wdata}, {1'b1, 4'b1111, 32'h100, 32'hDEADBEEF});
        end
      end
      if (core_done) begin
        done_at = i; vecs++;
        if (core_err !== ERR_NONE) begin errs++; $display("FAIL sw_err got %b want 00", core_err); end
      end
      @(negedge clk);
    end
    core_req = 1'b0; bus_ready = 1'b0;
    vecs++; if (done_at != 2) begin errs++; $display("FAIL sw_latency got %0d want 2", done_at); end
    vecs++; if (stalls != 2) begin errs++; $display("FAIL sw_stalls got %0d want 2", stalls); end
    vecs++; if (hs != 1) begin errs++; $display("FAIL sw_handshakes got %0d want 1", hs); end
    #1;
    vecs++; if (core_done !== 1'b0) begin errs++; $display("FAIL sw_done_pulse got %b want 0", core_done); end
  endtask

  task automatic test_store_byte();
    int rc, hs, done_at, dones;
    rc = 0; hs = 0; done_at = -1; dones = 0;
    @(negedge clk); drive_req(1'b1, F3_B, 32'h103, 32'h000000A5); bus_ready = 1'b0;
    for (int i = 0; i < 20 && done_at < 0; i++) begin
      #1;
      if (bus_valid) begin
        rc++;
        bus_ready = (rc >= 3);
        vecs++;
        if ({bus_we, bus_be, bus_addr, bus_wdata} !== {1'b1, 4'b1000, 32'h100, 32'hA5A5A5A5}) begin
          errs++; $display("FAIL sb_payload cycle %0d got %h want %h", rc, {bus_we, bus_be, bus_addr, bus_wdata}, {1'b1, 4'b1000, 32'h100, 32'hA5A5A5A5});
        end
        if (bus_ready) hs++;
      end else begin
        bus_ready = 1'b0;
      end
      if (core_done) begin done_at = i; dones++; end
      @(negedge clk);
    end
    core_req = 1'b0; bus_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin #1; if (core_done) dones++; @(negedge clk); end
    vecs++; if (done_at != 4) begin errs++; $display("FAIL sb_latency got %0d want 4", done_at); end
    vecs++; if (rc != 3) begin errs++; $display("FAIL sb_valid_cycles got %0d want 3", rc); end
    vecs++; if (hs != 1 || dones != 1) begin errs++; $display("FAIL sb_once got hs=%0d done=%0d want 1/1", hs, dones); end
  endtask

  task automatic test_loads();
    logic [2:0]  f3t [7] = '{F3_B, F3_BU, F3_H, F3_HU, F3_H, F3_B, F3_W};
    logic [31:0] at  [7] = '{32'h202, 32'h202, 32'h202, 32'h200, 32'h200, 32'h201, 32'h200};
    logic [3:0]  bet [7] = '{4'b0100, 4'b0100, 4'b1100, 4'b0011, 4'b0011, 4'b0010, 4'b1111};
    logic [31:0] rt  [7] = '{32'hFFFFFFF0, 32'h000000F0, 32'h000012F0, 32'h00008034,
                             32'hFFFF8034, 32'hFFFFFF80, 32'h12F08034};
    for (int k = 0; k < 7; k++) begin
      int w, hsd, done_at;
      w = 0; hsd = 0; done_at = -1;
      @(negedge clk); drive_req(1'b0, f3t[k], at[k], 32'h0); bus_ready = 1'b1;
      for (int i = 0; i < 20 && done_at < 0; i++) begin
        #1;
        bus_rvalid = 1'b0; bus_rdata = 32'h0BADF00D;
        if (hsd != 0) begin
          w++;
          if (w == 2) begin bus_rvalid = 1'b1; bus_rdata = 32'h12F08034; end
        end
        if (bus_valid && bus_ready) begin
          hsd = 1; vecs++;
          if ({bus_we, bus_be, bus_addr} !== {1'b0, bet[k], 32'h200}) begin
            errs++; $display("FAIL ld%0d_req got %h want %h", k, {bus_we, bus_be, bus_addr}, {1'b0, bet[k], 32'h200});
          end
        end
        if (core_done) begin
          done_at = i; vecs++;
          if (core_rdata !== rt[k] || core_err !== ERR_NONE) begin
            errs++; $display("FAIL ld%0d_data got %h/%b want %h/00", k, core_rdata, core_err, rt[k]);
          end
        end
        @(negedge clk);
      end
      core_req = 1'b0; bus_ready = 1'b0; bus_rvalid = 1'b0;
      vecs++; if (done_at != 4) begin errs++; $display("FAIL ld%0d_latency got %0d want 4", k, done_at); end
    end
  endtask

  task automatic test_misaligned();
    logic        wet [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [2:0]  f3t [5] = '{F3_W, F3_H, 3'b100, 3'b011, F3_H};
    logic [31:0] at  [5] = '{32'h105, 32'h101, 32'h100, 32'h100, 32'h103};
    for (int k = 0; k < 5; k++) begin
      int vc, done_at;
      vc = 0; done_at = -1;
      @(negedge clk); drive_req(wet[k], f3t[k], at[k], 32'h55667788); bus_ready = 1'b1;
      for (int i = 0; i < 10 && done_at < 0; i++) begin
        #1;
        if (bus_valid) vc++;
        if (core_done) begin
          done_at = i; vecs++;
          if (core_err !== ERR_MISAL || core_rdata !== 32'h12F08034) begin
            errs++; $display("FAIL mis%0d_err got %b/%h want 01/12f08034", k, core_err, core_rdata);
          end
        end
        @(negedge clk);
      end
      core_req = 1'b0; bus_ready = 1'b0;
      vecs++;
      if (done_at != 1 || vc != 0) begin
        errs++; $display("FAIL mis%0d_path got done_at=%0d valid=%0d want 1/0", k, done_at, vc);
      end
    end
  endtask

  task automatic test_timeout();
    int ready_at [2] = '{0, 4};
    for (int k = 0; k < 2; k++) begin
      int vc, done_at;
      vc = 0; done_at = -1;
      @(negedge clk); drive_req(1'b1, F3_W, 32'h300, 32'h01020304); bus_ready = 1'b0;
      for (int i = 0; i < 20 && done_at < 0; i++) begin
        #1;
        if (bus_valid) begin
          vc++;
          bus_ready = (ready_at[k] != 0) && (vc >= ready_at[k]);
        end else begin
          bus_ready = 1'b0;
        end
        if (core_done) begin
          done_at = i; vecs++;
          if (core_err !== ERR_TIMEOUT || bus_valid !== 1'b0) begin
            errs++; $display("FAIL to%0d_err got %b/%b want 10/0", k, core_err, bus_valid);
          end
        end
        @(negedge clk);
      end
      core_req = 1'b0; bus_ready = 1'b0;
      vecs++;
      if (vc != 4 || done_at != 5) begin
        errs++; $display("FAIL to%0d_len got valid=%0d done_at=%0d want 4/5", k, vc, done_at);
      end
    end
  endtask

  task automatic test_req_drop();
    int vc, done_at;
    vc = 0; done_at = -1;
    @(negedge clk); drive_req(1'b1, F3_H, 32'h106, 32'h0000BEEF); bus_ready = 1'b0;
    for (int i = 0; i < 20 && done_at < 0; i++) begin
      #1;
      if (i == 1) core_req = 1'b0;
      if (bus_valid) begin
        vc++;
        bus_ready = (vc >= 2);
        if (bus_ready) begin
          vecs++;
          if ({bus_be, bus_addr, bus_wdata, core_stall} !== {4'b1100, 32'h104, 32'hBEEFBEEF, 1'b0}) begin
            errs++; $display("FAIL drop_payload got %h want %h", {bus_be, bus_addr, bus_wdata, core_stall}, {4'b1100, 32'h104, 32'hBEEFBEEF, 1'b0});
          end
        end
      end
      if (core_done) begin
        done_at = i; vecs++;
        if (core_err !== ERR_NONE) begin errs++; $display("FAIL drop_err got %b want 00", core_err); end
      end
      @(negedge clk);
    end
    bus_ready = 1'b0;
    vecs++; if (done_at != 3) begin errs++; $display("FAIL drop_latency got %0d want 3", done_at); end
  endtask

  task automatic test_reset_mid();
    int dones;
    dones = 0;
    @(negedge clk); drive_req(1'b0, F3_W, 32'h200, 32'h0); bus_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    core_req = 1'b0; bus_ready = 1'b0;
    #1;
    vecs++;
    if ({bus_valid, core_done} !== 2'b00) begin errs++; $display("FAIL rstmid_wait got %b want 00", {bus_valid, core_done}); end
    #1 rst = 1'b0;
    #1;
    vecs++;
    if ({core_stall, core_done, core_err, bus_valid, bus_we, bus_be, bus_addr, bus_wdata, core_rdata} !== '0) begin
      errs++; $display("FAIL rstmid_async got rdata=%h valid=%b done=%b want all 0", core_rdata, bus_valid, core_done);
    end
    @(negedge clk); rst = 1'b1; bus_rvalid = 1'b1; bus_rdata = 32'hCAFEF00D;
    for (int i = 0; i < 4; i++) begin #1; if (core_done) dones++; @(negedge clk); end
    bus_rvalid = 1'b0;
    vecs++;
    if (dones != 0 || core_rdata !== 32'h0) begin
      errs++; $display("FAIL rstmid_stale got done=%0d rdata=%h want 0/0", dones, core_rdata);
    end
  endtask

  initial begin
    test_reset();
    test_store_word();
    test_store_byte();
    test_loads();
    test_misaligned();
    test_timeout();
    test_req_drop();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
